fazyrv_dmem_rsp: RTL and testbench

Wishbone-classic data-memory responder on the FazyRV data bus, at the memory end of the dmem port. The core's data scratchpad delivers aligned store words and consumes returned load words. This block serves those requests from an internal word-organised RAM. It applies byte-lane enables, inserts a programmable number of wait states, flags out-of-range accesses, and returns read data with a single-cycle acknowledge. It is used in SoC tops and in benches as the reference data memory.

---
 rtl/fazyrv_dmem_rsp.sv | 152 +++++++++++++++
 tb/tb_fazyrv_dmem_rsp.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fazyrv_dmem_rsp.sv
// fazyrv_dmem_rsp
//   Wishbone-classic data-memory responder for the FazyRV dmem port.
//   Serves load/store requests from an internal word-organised RAM. It applies
//   byte-lane enables, inserts LAT wait states and flags out-of-range accesses.
//   It returns read data with a registered, single-cycle acknowledge.
//
// Parameters
//   DEPTH      memory size in 32-bit words (power of two, >= 2)
//   LAT        wait states between acceptance and ack (0..15)
//   INIT_FILE  kept for interface compatibility; no image is loaded
//
// Ports
//   clk_i           clock, rising edge
//   rst_i           synchronous active-high reset
//   wb_dmem_cyc_i   bus cycle active
//   wb_dmem_stb_i   request strobe
//   wb_dmem_we_i    1 = store, 0 = load
//   wb_dmem_be_i    byte enables, bit k selects dat[8k+7:8k]
//   wb_dmem_adr_i   byte address (bits [1:0] ignored)
//   wb_dmem_dat_i   lane-aligned store data
//   wb_dmem_dat_o   load data, valid with ack, 0 otherwise
//   wb_dmem_ack_o   single-cycle transfer-done pulse
//   wb_dmem_err_o   out-of-range flag, only together with ack
module fazyrv_dmem_rsp #(
  parameter int unsigned DEPTH     = 1024,
  parameter int unsigned LAT       = 0,
  parameter string       INIT_FILE = ""
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        wb_dmem_cyc_i,
  input  logic        wb_dmem_stb_i,
  input  logic        wb_dmem_we_i,
  input  logic [3:0]  wb_dmem_be_i,
  input  logic [31:0] wb_dmem_adr_i,
  input  logic [31:0] wb_dmem_dat_i,
  output logic [31:0] wb_dmem_dat_o,
  output logic        wb_dmem_ack_o,
  output logic        wb_dmem_err_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACK
  } state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic [29:0] adr_q;
  logic        we_q;
  logic [3:0]  be_q;
  logic [31:0] dat_q;

  logic [31:0] mem [DEPTH];

  logic          req;
  logic          oor_in;
  logic          oor_q;
  logic          wr_en;
  logic [AW-1:0] wr_idx;
  logic [3:0]    wr_be;
  logic [31:0]   wr_dat;
  logic          unused_adr;

  assign unused_adr = ^wb_dmem_adr_i[1:0];

  assign req    = wb_dmem_cyc_i & wb_dmem_stb_i;
  // Any index bit above the RAM width means out of range: no wrap/aliasing.
  assign oor_in = |wb_dmem_adr_i[31:AW+2];
  assign oor_q  = |adr_q[29:AW];

  // The write lands on the edge that enters ACK. With LAT == 0 that is the
  // acceptance edge itself, so the write port takes the bus inputs directly.
  always_comb begin
    wr_en  = 1'b0;
    wr_idx = adr_q[AW-1:0];
    wr_be  = be_q;
    wr_dat = dat_q;
    if (!rst_i) begin
      case (state)
        IDLE: begin
          if (req && LAT == 0 && wb_dmem_we_i && !oor_in) begin
            wr_en  = 1'b1;
            wr_idx = wb_dmem_adr_i[AW+1:2];
            wr_be  = wb_dmem_be_i;
            wr_dat = wb_dmem_dat_i;
          end
        end
        WAIT: begin
          if (wb_dmem_cyc_i && cnt == 4'd1 && we_q && !oor_q) begin
            wr_en = 1'b1;
          end
        end
        default: wr_en = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    for (int unsigned k = 0; k < 4; k++) begin
      if (wr_en && wr_be[k]) begin
        mem[wr_idx][8*k +: 8] <= wr_dat[8*k +: 8];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state         <= IDLE;
      cnt           <= '0;
      wb_dmem_ack_o <= 1'b0;
      wb_dmem_err_o <= 1'b0;
      wb_dmem_dat_o <= '0;
    end else begin
      wb_dmem_ack_o <= 1'b0;
      wb_dmem_err_o <= 1'b0;
      wb_dmem_dat_o <= '0;
      case (state)
        IDLE: begin
          if (req) begin
            adr_q <= wb_dmem_adr_i[31:2];
            we_q  <= wb_dmem_we_i;
            be_q  <= wb_dmem_be_i;
            dat_q <= wb_dmem_dat_i;
            cnt   <= 4'(LAT);
            state <= (LAT == 0) ? ACK : WAIT;
          end
        end
        WAIT: begin
          if (!wb_dmem_cyc_i) begin
            state <= IDLE;
          end else if (cnt == 4'd1) begin
            state <= ACK;
          end
          cnt <= cnt - 4'd1;
        end
        ACK: begin
          // ACK ignores stb; a held request is taken in the following IDLE cycle.
          wb_dmem_ack_o <= 1'b1;
          wb_dmem_err_o <= oor_q;
          wb_dmem_dat_o <= (we_q || oor_q) ? '0 : mem[adr_q[AW-1:0]];
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fazyrv_dmem_rsp.sv
module tb_fazyrv_dmem_rsp;

    localparam int unsigned DEPTH = 1024;
    localparam int LATS [3] = '{0, 3, 5};

    logic        clk = 1'b0;
    logic        rst;
    logic        cyc [3];
    logic        stb [3];
    logic        we  [3];
    logic [3:0]  be  [3];
    logic [31:0] adr [3];
    logic [31:0] wdat[3];
    logic [31:0] rdat[3];
    logic        ack [3];
    logic        err [3];

    int nchk = 0;
    int nerr = 0;
    bit chk_en = 0;

    always #5 clk = ~clk;

    fazyrv_dmem_rsp #(.DEPTH(DEPTH), .LAT(0)) u_lat0 (
        .clk_i(clk), .rst_i(rst),
        .wb_dmem_cyc_i(cyc[0]), .wb_dmem_stb_i(stb[0]), .wb_dmem_we_i(we[0]),
        .wb_dmem_be_i(be[0]), .wb_dmem_adr_i(adr[0]), .wb_dmem_dat_i(wdat[0]),
        .wb_dmem_dat_o(rdat[0]), .wb_dmem_ack_o(ack[0]), .wb_dmem_err_o(err[0])
    );

    fazyrv_dmem_rsp #(.DEPTH(DEPTH), .LAT(3)) u_lat3 (
        .clk_i(clk), .rst_i(rst),
        .wb_dmem_cyc_i(cyc[1]), .wb_dmem_stb_i(stb[1]), .wb_dmem_we_i(we[1]),
        .wb_dmem_be_i(be[1]), .wb_dmem_adr_i(adr[1]), .wb_dmem_dat_i(wdat[1]),
        .wb_dmem_dat_o(rdat[1]), .wb_dmem_ack_o(ack[1]), .wb_dmem_err_o(err[1])
    );

    fazyrv_dmem_rsp #(.DEPTH(DEPTH), .LAT(5)) u_lat5 (
        .clk_i(clk), .rst_i(rst),
        .wb_dmem_cyc_i(cyc[2]), .wb_dmem_stb_i(stb[2]), .wb_dmem_we_i(we[2]),
        .wb_dmem_be_i(be[2]), .wb_dmem_adr_i(adr[2]), .wb_dmem_dat_i(wdat[2]),
        .wb_dmem_dat_o(rdat[2]), .wb_dmem_ack_o(ack[2]), .wb_dmem_err_o(err[2])
    );

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endfunction

    // ---------------- reference model ----------------
    // Timeline per request accepted at edge A: WAIT edges A+1..A+LAT may abort
    // on cyc low; commit at edge A+LAT; ack registered at edge A+LAT+1.
    logic [31:0] mmem [3][DEPTH];
    bit          mval [3][DEPTH];
    longint      kcnt = 0;
    bit          busy [3];
    longint      acc  [3];
    logic        r_we [3];
    logic [3:0]  r_be [3];
    logic [31:0] r_adr[3];
    logic [31:0] r_dat[3];
    bit          e_ack[3];
    bit          e_err[3];
    logic [31:0] e_dat[3];
    bit          e_known[3];

    function automatic bit m_oor(logic [31:0] a);
        return a >= 32'(4 * DEPTH);
    endfunction

    task automatic m_commit(input int i);
        int idx;
        if (r_we[i] && !m_oor(r_adr[i])) begin
            idx = int'(r_adr[i] / 4);
            for (int k = 0; k < 4; k++)
                if (r_be[i][k]) mmem[i][idx][8*k +: 8] = r_dat[i][8*k +: 8];
            if (r_be[i] == 4'hF) mval[i][idx] = 1;
        end
    endtask

    always @(posedge clk) begin
        kcnt++;
        for (int i = 0; i < 3; i++) begin
            e_ack[i] = 0; e_err[i] = 0; e_dat[i] = '0; e_known[i] = 1;
            if (rst) begin
                busy[i] = 0;
            end else if (!busy[i]) begin
                if (cyc[i] && stb[i]) begin
                    busy[i] = 1; acc[i] = kcnt;
                    r_we[i] = we[i]; r_be[i] = be[i]; r_adr[i] = adr[i]; r_dat[i] = wdat[i];
                    if (LATS[i] == 0) m_commit(i);
                end
            end else if (kcnt <= acc[i] + LATS[i]) begin
                if (!cyc[i]) busy[i] = 0;
                else if (kcnt == acc[i] + LATS[i]) m_commit(i);
            end else begin
                busy[i] = 0;
                e_ack[i] = 1;
                e_err[i] = m_oor(r_adr[i]);
                if (e_err[i]) begin
                    e_dat[i] = '0;
                end else if (r_we[i]) begin
                    e_known[i] = 0;
                end else begin
                    e_dat[i]   = mmem[i][int'(r_adr[i] / 4)];
                    e_known[i] = mval[i][int'(r_adr[i] / 4)];
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("ack[%0d] t=%0t", i, $time), 32'(ack[i]), 32'(e_ack[i]));
                chk($sformatf("err[%0d] t=%0t", i, $time), 32'(err[i]), 32'(e_err[i]));
                if (!e_ack[i] || e_known[i])
                    chk($sformatf("dat[%0d] t=%0t", i, $time), rdat[i], e_dat[i]);
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic xfer(input int i, input logic w, input logic [3:0] b,
                        input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output logic e, output int lat);
        int n = 0;
        cyc[i] = 1; stb[i] = 1; we[i] = w; be[i] = b; adr[i] = a; wdat[i] = d;
        rd = '0; e = 0;
        while (1) begin
            @(posedge clk); #1;
            n++;
            if (ack[i]) break;
            if (n == 1) begin
                // Request is latched; changing inputs must not matter.
                we[i] = 1'($urandom); be[i] = 4'($urandom);
                adr[i] = $urandom; wdat[i] = $urandom;
            end
            if (n >= 40) begin
                chk($sformatf("timeout inst%0d", i), 32'(n), 32'(LATS[i] + 2));
                break;
            end
        end
        rd = rdat[i]; e = err[i]; lat = n - 1;
        cyc[i] = 0; stb[i] = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        logic        e;
        int          lat, n, first, second, acks;

        rst = 1;
        for (int i = 0; i < 3; i++) begin
            cyc[i] = 0; stb[i] = 0; we[i] = 0; be[i] = '0; adr[i] = '0; wdat[i] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("reset ack0", 32'(ack[0]), 0);
        chk("reset err0", 32'(err[0]), 0);
        chk("reset dat0", rdat[0], 0);
        rst = 0;
        chk_en = 1;

        // LAT=0 store/load
        xfer(0, 1, 4'hF, 32'h10, 32'hDEADBEEF, rd, e, lat);
        chk("lat0 store latency", 32'(lat), 1);
        xfer(0, 0, 4'hF, 32'h10, 32'h0, rd, e, lat);
        chk("lat0 load latency", 32'(lat), 1);
        chk("lat0 load data", rd, 32'hDEADBEEF);

        // byte lanes
        xfer(0, 1, 4'hF, 32'h20, 32'h11223344, rd, e, lat);
        xfer(0, 1, 4'h4, 32'h20, 32'h00AA0000, rd, e, lat);
        xfer(0, 0, 4'h1, 32'h20, 32'h0, rd, e, lat);
        chk("byte lane merge", rd, 32'h11AA3344);
        xfer(0, 1, 4'h0, 32'h20, 32'hFFFFFFFF, rd, e, lat);
        xfer(0, 0, 4'hF, 32'h22, 32'h0, rd, e, lat);
        chk("be0 no change", rd, 32'h11AA3344);

        // out of range and top word
        xfer(0, 1, 4'hF, 32'h0, 32'h5A5A5A5A, rd, e, lat);
        xfer(0, 1, 4'hF, 32'h1000, 32'hFFFFFFFF, rd, e, lat);
        chk("oor store err", 32'(e), 1);
        xfer(0, 0, 4'hF, 32'h1000, 32'h0, rd, e, lat);
        chk("oor load err", 32'(e), 1);
        chk("oor load dat", rd, 0);
        xfer(0, 0, 4'hF, 32'h0, 32'h0, rd, e, lat);
        chk("no alias word0", rd, 32'h5A5A5A5A);
        chk("word0 err", 32'(e), 0);
        xfer(0, 1, 4'hF, 32'hFFC, 32'h7E57CAFE, rd, e, lat);
        xfer(0, 0, 4'hF, 32'hFFC, 32'h0, rd, e, lat);
        chk("top word data", rd, 32'h7E57CAFE);
        chk("top word err", 32'(e), 0);

        // LAT=3 with stb held across two transfers
        xfer(1, 1, 4'hF, 32'h0, 32'h600DF00D, rd, e, lat);
        chk("lat3 store latency", 32'(lat), 4);
        cyc[1] = 1; stb[1] = 1; we[1] = 0; be[1] = 4'hF; adr[1] = 32'h0; wdat[1] = '0;
        n = 0; first = 0; second = 0;
        while (second == 0 && n < 40) begin
            @(posedge clk); #1;
            n++;
            if (ack[1]) begin
                if (first == 0) first = n;
                else second = n;
            end
        end
        cyc[1] = 0; stb[1] = 0;
        chk("held first latency", 32'(first - 1), 4);
        chk("held ack spacing", 32'(second - first), 5);

        // LAT=5 abort
        xfer(2, 1, 4'hF, 32'h40, 32'h0BADC0DE, rd, e, lat);
        chk("lat5 store latency", 32'(lat), 6);
        cyc[2] = 1; stb[2] = 1; we[2] = 1; be[2] = 4'hF; adr[2] = 32'h40; wdat[2] = 32'hCAFEF00D;
        repeat (3) begin @(posedge clk); #1; end
        cyc[2] = 0; stb[2] = 0;
        acks = 0;
        repeat (10) begin @(posedge clk); #1; if (ack[2]) acks++; end
        chk("abort no ack", 32'(acks), 0);
        xfer(2, 0, 4'hF, 32'h40, 32'h0, rd, e, lat);
        chk("abort no write", rd, 32'h0BADC0DE);

        // reset during WAIT
        xfer(2, 1, 4'hF, 32'h44, 32'h01234567, rd, e, lat);
        cyc[2] = 1; stb[2] = 1; we[2] = 1; be[2] = 4'hF; adr[2] = 32'h44; wdat[2] = 32'h55555555;
        repeat (3) begin @(posedge clk); #1; end
        rst = 1;
        @(posedge clk); #1;
        chk("rst ack", 32'(ack[2]), 0);
        chk("rst err", 32'(err[2]), 0);
        chk("rst dat", rdat[2], 0);
        rst = 0;
        xfer(2, 0, 4'hF, 32'h44, 32'h0, rd, e, lat);
        chk("post-reset latency", 32'(lat), 6);
        chk("rst no write", rd, 32'h01234567);

        // randomized traffic against the model
        for (int i = 0; i < 3; i++) begin
            for (int w = 0; w < 36; w++) begin
                int word = (w < 32) ? w : (DEPTH - 36 + w);
                xfer(i, 1, 4'hF, 32'(word * 4), $urandom, rd, e, lat);
            end
            for (int t = 0; t < 60; t++) begin
                int unsigned cls = $urandom_range(0, 9);
                logic [31:0] a;
                if (cls < 7)       a = 32'($urandom_range(0, 31) * 4);
                else if (cls == 7) a = 32'($urandom_range(DEPTH - 4, DEPTH - 1) * 4);
                else if (cls == 8) a = 32'(4 * DEPTH + $urandom_range(0, 63) * 4);
                else               a = (32'd1 << $urandom_range(12, 31)) | ($urandom & 32'hFFF);
                a[1:0] = 2'($urandom);
                xfer(i, 1'($urandom), 4'($urandom), a, $urandom, rd, e, lat);
                chk($sformatf("rand latency inst%0d", i), 32'(lat), 32'(LATS[i] + 1));
                repeat ($urandom_range(0, 2)) @(posedge clk);
                #1;
            end
        end

        @(posedge clk); #1;
        chk_en = 0;
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
